// File: rtl/decode_stage.sv
// RV32I decode: register_file addressing, writeback bypass, immediate/control generation into ID/EX.
// One cycle from accept to ex_valid; if_ready drops on reset, flush, load-use hazard or a stalled ID/EX.
module decode_stage #(
  parameter int unsigned         XLEN     = 32,
  parameter logic [XLEN-1:0]     RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            if_valid,
  output logic            if_ready,
  input  logic [31:0]     if_instr,
  input  logic [XLEN-1:0] if_pc,
  output logic [4:0]      rs_1,
  output logic [4:0]      rs_2,
  input  logic [XLEN-1:0] read_data_1,
  input  logic [XLEN-1:0] read_data_2,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            wb_we,
  input  logic            flush,
  input  logic            ex_ready,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_rs1_val,
  output logic [XLEN-1:0] ex_rs2_val,
  output logic [XLEN-1:0] ex_imm,
  output logic [4:0]      ex_rd,
  output logic [6:0]      ex_opcode,
  output logic [2:0]      ex_funct3,
  output logic            ex_funct7b5,
  output logic            ex_reg_write,
  output logic            ex_mem_read,
  output logic            ex_illegal
);

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic [XLEN-1:0] imm;
    logic [4:0]      rd;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic            funct7b5;
    logic            reg_write;
    logic            mem_read;
    logic            illegal;
  } idex_t;

  localparam idex_t IDEX_RESET = '{pc: RESET_PC, default: '0};

  idex_t idex_q, idex_d;

  logic [6:0]      opcode;
  logic [4:0]      rd_field;
  logic            is_lui, is_auipc, is_jal, is_jalr, is_branch, is_load;
  logic            is_store, is_op_imm, is_op, is_misc_mem, is_system;
  logic            legal, has_rd, uses_rs1, uses_rs2;
  logic            hazard, accept;
  logic [XLEN-1:0] imm;
  logic [XLEN-1:0] rs1_val, rs2_val;

  assign opcode   = if_instr[6:0];
  assign rd_field = if_instr[11:7];
  assign rs_1     = if_instr[19:15];
  assign rs_2     = if_instr[24:20];

  assign is_lui      = (opcode == OPC_LUI);
  assign is_auipc    = (opcode == OPC_AUIPC);
  assign is_jal      = (opcode == OPC_JAL);
  assign is_jalr     = (opcode == OPC_JALR);
  assign is_branch   = (opcode == OPC_BRANCH);
  assign is_load     = (opcode == OPC_LOAD);
  assign is_store    = (opcode == OPC_STORE);
  assign is_op_imm   = (opcode == OPC_OP_IMM);
  assign is_op       = (opcode == OPC_OP);
  assign is_misc_mem = (opcode == OPC_MISC_MEM);
  assign is_system   = (opcode == OPC_SYSTEM);

  assign legal    = is_lui | is_auipc | is_jal | is_jalr | is_branch | is_load |
                    is_store | is_op_imm | is_op | is_misc_mem | is_system;
  assign has_rd   = is_lui | is_auipc | is_jal | is_jalr | is_load | is_op_imm | is_op;
  assign uses_rs1 = !(is_lui | is_auipc | is_jal);
  assign uses_rs2 = is_branch | is_store | is_op;

  // Load-use: the loaded value is not yet available for bypass, so hold fetch until the load leaves.
  assign hazard = idex_q.valid && idex_q.mem_read && (idex_q.rd != 5'd0) &&
                  ((uses_rs1 && (idex_q.rd == rs_1)) || (uses_rs2 && (idex_q.rd == rs_2)));

  assign if_ready = !reset && !flush && !hazard && (!idex_q.valid || ex_ready);
  assign accept   = if_valid && if_ready;

  always_comb begin
    imm = '0;
    unique case (1'b1)
      is_load, is_op_imm, is_jalr:
        imm = {{20{if_instr[31]}}, if_instr[31:20]};
      is_store:
        imm = {{20{if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
      is_branch:
        imm = {{19{if_instr[31]}}, if_instr[31], if_instr[7], if_instr[30:25],
               if_instr[11:8], 1'b0};
      is_lui, is_auipc:
        imm = {if_instr[31:12], 12'b0};
      is_jal:
        imm = {{11{if_instr[31]}}, if_instr[31], if_instr[19:12], if_instr[20],
               if_instr[30:21], 1'b0};
      default:
        imm = '0;
    endcase
  end

  function automatic logic [XLEN-1:0] bypass(
    input logic [4:0]      rs,
    input logic [XLEN-1:0] rf_data,
    input logic            we,
    input logic [4:0]      wrd,
    input logic [XLEN-1:0] wdata
  );
    if (rs == 5'd0) begin
      return '0;
    end else if (we && (wrd == rs)) begin
      return wdata;
    end
    return rf_data;
  endfunction

  assign rs1_val = bypass(rs_1, read_data_1, wb_we, wb_rd, wb_data);
  assign rs2_val = bypass(rs_2, read_data_2, wb_we, wb_rd, wb_data);

  always_comb begin
    idex_d = idex_q;
    if (flush) begin
      idex_d.valid = 1'b0;
    end else if (accept) begin
      idex_d.valid     = 1'b1;
      idex_d.pc        = if_pc;
      idex_d.rs1_val   = rs1_val;
      idex_d.rs2_val   = rs2_val;
      idex_d.imm       = imm;
      idex_d.rd        = has_rd ? rd_field : 5'd0;
      idex_d.opcode    = opcode;
      idex_d.funct3    = if_instr[14:12];
      idex_d.funct7b5  = if_instr[30];
      idex_d.reg_write = has_rd && (rd_field != 5'd0);
      idex_d.mem_read  = is_load;
      idex_d.illegal   = !legal;
    end else if (ex_ready) begin
      idex_d.valid = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idex_q <= IDEX_RESET;
    end else begin
      idex_q <= idex_d;
    end
  end

  assign ex_valid     = idex_q.valid;
  assign ex_pc        = idex_q.pc;
  assign ex_rs1_val   = idex_q.rs1_val;
  assign ex_rs2_val   = idex_q.rs2_val;
  assign ex_imm       = idex_q.imm;
  assign ex_rd        = idex_q.rd;
  assign ex_opcode    = idex_q.opcode;
  assign ex_funct3    = idex_q.funct3;
  assign ex_funct7b5  = idex_q.funct7b5;
  assign ex_reg_write = idex_q.reg_write;
  assign ex_mem_read  = idex_q.mem_read;
  assign ex_illegal   = idex_q.illegal;

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- RV32I instruction-decode stage sitting directly upstream of register_file.
- Drives rs_1/rs_2 from the fetched instruction, consumes read_data_1/read_data_2 and applies writeback bypass.
- Generates the immediate and control fields, and registers everything into an ID/EX pipeline register.
- Uses a valid/ready handshake on both sides, and handles load-use stalls and flushes.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- RESET_PC, 32'h0000_0000, value driven on ex_pc while reset.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- if_valid  input  1  fetch presents an instruction.
- if_ready  output  1  decode accepts the instruction this cycle.
- if_instr  input  32  instruction word.
- if_pc  input  32  PC of if_instr.
- rs_1  output  5  register_file read address 1; combinational, equals if_instr[19:15].
- rs_2  output  5  register_file read address 2; combinational, equals if_instr[24:20].
- read_data_1  input  32  register_file data for rs_1 (x0 reads as 0).
- read_data_2  input  32  register_file data for rs_2.
- wb_rd  input  5  writeback destination.
- wb_data  input  32  writeback data.
- wb_we  input  1  writeback write enable.
- flush  input  1  kill the ID/EX contents and drop any accept this cycle (branch redirect).
- ex_ready  input  1  execute accepts ID/EX contents.
- ex_valid  output  1  ID/EX register holds a valid instruction.
- ex_pc  output  32  registered PC.
- ex_rs1_val  output  32  registered operand 1 after bypass.
- ex_rs2_val  output  32  registered operand 2 after bypass.
- ex_imm  output  32  registered sign-extended immediate.
- ex_rd  output  5  destination register; forced to 0 when the instruction has no rd.
- ex_opcode  output  7  if_instr[6:0].
- ex_funct3  output  3  if_instr[14:12].
- ex_funct7b5  output  1  if_instr[30].
- ex_reg_write  output  1  instruction writes rd, and rd != 0.
- ex_mem_read  output  1  instruction is a LOAD.
- ex_illegal  output  1  opcode is not in the RV32I base set.

Behaviour:
- Reset (synchronous, cycle reset is sampled high): ex_valid=0, ex_pc=RESET_PC. All other ex_* outputs are 0.
- if_ready is combinational and is not affected by if_valid:
  - if_ready = !reset && !flush && !hazard && (!ex_valid || ex_ready).
- Accept = if_valid && if_ready. On accept, the ID/EX register loads the decoded fields and ex_valid=1. Latency is 1 cycle from accept to ex_valid.
- Hold: ex_valid && !ex_ready && !flush leaves all ex_* outputs unchanged.
- Drain: ex_ready && ex_valid without an accept gives ex_valid=0 next cycle (bubble). Data fields may hold stale values.
- hazard = ex_valid && ex_mem_read && ex_rd!=0 && ((uses_rs1 && ex_rd==rs_1) || (uses_rs2 && ex_rd==rs_2)).
  - uses_rs1: all opcodes except LUI, AUIPC, JAL.
  - uses_rs2: BRANCH, STORE, OP.
  - A hazard blocks accept for exactly the cycles it holds. The load leaves when ex_ready=1 and a bubble follows.
- Bypass is applied per operand, independently for each, with priority as listed:
  - rs==0 gives 0.
  - else wb_we && wb_rd==rs gives wb_data.
  - else register_file data.
- Immediate by opcode:
  - I-type: LOAD, OP-IMM, JALR.
  - S-type: STORE.
  - B-type: BRANCH, bit0=0.
  - U-type: LUI, AUIPC, low 12 bits = 0.
  - J-type: JAL, bit0=0.
  - All others: 0.
  - Sign bit is always if_instr[31].
- No rd: BRANCH, STORE, MISC-MEM, SYSTEM, and illegal opcodes give ex_rd=0 and ex_reg_write=0.
- Illegal opcode: accepted normally with ex_illegal=1. ex_reg_write=0 and ex_mem_read=0.
- flush:
  - Next cycle ex_valid=0.
  - if_ready=0 in the flush cycle, so no instruction is consumed.
  - flush overrides hold and hazard.
- reset mid-operation: same as flush plus the reset values. if_ready=0 during reset.
- Simultaneous ex_ready and accept: the register replaces its contents in the same edge (full throughput, 1 instr/cycle).

Test Plan:
- ADDI x5,x0,-1 (32'hFFF00293), if_valid=1, ex_ready=1 -> 1 cycle later ex_valid=1, ex_imm=32'hFFFFFFFF, ex_rd=5, ex_reg_write=1, ex_rs1_val=0.
- LW x3,0(x1) accepted, then ADD x4,x3,x2 presented with ex_ready=1 -> if_ready=0 for 1 cycle and a bubble appears (ex_valid=0). ADD is accepted the following cycle.
- ADD x6,x7,x8 with read_data_1=0x11, wb_we=1, wb_rd=7, wb_data=0xAA -> ex_rs1_val=0xAA, ex_rs2_val=read_data_2.
- ex_valid=1, ex_ready=0 for 3 cycles with new if_valid -> if_ready=0 and ex_* stable. ex_ready=1 -> next instruction loaded on the same edge.
- flush asserted with ex_valid=1 and if_valid=1 -> if_ready=0, ex_valid=0 next cycle, fetched instruction not consumed.
- BEQ with imm=-4 (32'hFE000EE3) -> ex_imm=32'hFFFFFFFC, ex_rd=0, ex_reg_write=0. Opcode 7'b0000000 -> ex_illegal=1.
